// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// index/data widths, round-robin state encoding, contention counter width.
package regfile_wb_arbiter_pkg;

  localparam int REG_IDX_W     = 5;
  localparam int DATAWIDTH_DEF = 32;
  localparam int CNT_W         = 16;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } rr_state_e;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-requester round-robin grant logic for writeback (ALU vs. load unit).
// Grants are combinational from the valids; only the priority state is held.
// Priority flips only when both requesters compete and one of them wins.
module wb_rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hold,
  input  logic i_req_alu,
  input  logic i_req_lsu,
  output logic o_gnt_alu,
  output logic o_gnt_lsu
);

  rr_state_e r_state;
  logic      w_contended;

  assign w_contended = !i_hold && i_req_alu && i_req_lsu;

  // Grant selection: hold blocks everyone, a lone requester always wins,
  // and under contention the current priority holder wins.
  always_comb begin
    o_gnt_alu = 1'b0;
    o_gnt_lsu = 1'b0;
    if (!i_hold) begin
      if (i_req_alu && (!i_req_lsu || r_state == PRI_ALU)) begin
        o_gnt_alu = 1'b1;
      end else if (i_req_lsu) begin
        o_gnt_lsu = 1'b1;
      end
    end
  end

  // Priority FSM: after a contended grant, the loser gets priority next time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= PRI_ALU;
    end else if (w_contended) begin
      r_state <= o_gnt_alu ? PRI_LSU : PRI_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load-unit writebacks into
// the single register-file write port. Writes to x0 are accepted but dropped.
// Optional contention counter enabled by defining WB_ARB_CONFLICT_CNT_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [DATAWIDTH-1:0] alu_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [DATAWIDTH-1:0] lsu_data,
  output logic                 lsu_ready,
  output logic                 write,
  output logic [REG_IDX_W-1:0] writeReg,
  output logic [DATAWIDTH-1:0] writeData
`ifdef WB_ARB_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0]     conflict_cnt
`endif
);

  logic                 w_gnt_alu;
  logic                 w_gnt_lsu;
  logic                 w_xfer;
  logic [REG_IDX_W-1:0] w_rd;
  logic [DATAWIDTH-1:0] w_data;
  logic                 r_write;
  logic [REG_IDX_W-1:0] r_write_reg;
  logic [DATAWIDTH-1:0] r_write_data;

  wb_rr_arbiter2 u_rr (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_hold    (hold),
    .i_req_alu (alu_valid),
    .i_req_lsu (lsu_valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_lsu (w_gnt_lsu)
  );

  assign alu_ready = w_gnt_alu;
  assign lsu_ready = w_gnt_lsu;
  assign w_xfer    = w_gnt_alu || w_gnt_lsu;

  // Datapath mux: forward the granted requester's index and data.
  always_comb begin
    w_rd   = lsu_rd;
    w_data = lsu_data;
    if (w_gnt_alu) begin
      w_rd   = alu_rd;
      w_data = alu_data;
    end
  end

  // Output stage: one-cycle write pulse; index/data only change on a real write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_write <= w_xfer && (w_rd != '0);
      if (w_xfer && (w_rd != '0)) begin
        r_write_reg  <= w_rd;
        r_write_data <= w_data;
      end
    end
  end

  assign write     = r_write;
  assign writeReg  = r_write_reg;
  assign writeData = r_write_data;

`ifdef WB_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] r_conflict_cnt;

  // Contention counter: counts unheld cycles where both requesters compete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (!hold && alu_valid && lsu_valid) begin
      r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus constrained
// random traffic, with a queue-based scoreboard and a negedge monitor.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        write;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
`ifdef WB_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  regfile_wb_arbiter #(.DATAWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .write     (write),
    .writeReg  (writeReg),
    .writeData (writeData)
`ifdef WB_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          m_pri_lsu;      // reference: who wins the next contended cycle
  int unsigned m_cnt;          // reference: contended cycles seen, saturating
  logic [4:0]  last_rd;        // reference: last register-file write
  logic [31:0] last_d;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic reset_model();
    exp_q.delete();
    m_pri_lsu = 1'b0;
    m_cnt     = 0;
    last_rd   = '0;
    last_d    = '0;
  endtask

  // Monitor: every write must match the oldest outstanding expectation;
  // with no write, the index/data outputs must keep the last written values.
  always @(negedge clk) begin
    if (!rst) begin
      if (write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(write), 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("writeReg", 32'(writeReg), 32'(e.rd));
          check("writeData", writeData, e.d);
          last_rd = e.rd;
          last_d  = e.d;
        end
      end else begin
        check("hold_writeReg", 32'(writeReg), 32'(last_rd));
        check("hold_writeData", writeData, last_d);
      end
    end
  end

  // One arbitration cycle: drive inputs, check readies against the reference
  // rules, then record the expected write and advance the reference state.
  task automatic drive_cycle(input logic h, input logic av, input logic [4:0] ard,
                             input logic [31:0] adat, input logic lv,
                             input logic [4:0] lrd, input logic [31:0] ldat,
                             output logic ag, output logic lg);
    @(posedge clk);
    #1;
    hold = h; alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    #1;
    ag = !h && av && (!lv || !m_pri_lsu);
    lg = !h && lv && (!av || m_pri_lsu);
    check("alu_ready", 32'(alu_ready), 32'(ag));
    check("lsu_ready", 32'(lsu_ready), 32'(lg));
`ifdef WB_ARB_CONFLICT_CNT_EN
    check("conflict_cnt", 32'(conflict_cnt), m_cnt);
`endif
    if (ag && ard != 5'd0) exp_q.push_back('{ard, adat});
    if (lg && lrd != 5'd0) exp_q.push_back('{lrd, ldat});
    if (!h && av && lv) begin
      m_pri_lsu = ag;
      if (m_cnt < 32'hFFFF) m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    logic ga, gl;
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, ga, gl);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    hold = 0; alu_valid = 0; lsu_valid = 0;
    rst = 1'b1;
    #1;
    check("rst_write", 32'(write), 32'd0);
    check("rst_writeReg", 32'(writeReg), 32'd0);
    check("rst_writeData", writeData, 32'd0);
    reset_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic ga, gl;
    logic        a_v, l_v, a_keep, l_keep;
    logic [4:0]  a_rd, l_rd;
    logic [31:0] a_d, l_d;

    rst = 1'b1; hold = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    reset_model();
    #1;
    check("async_rst_write", 32'(write), 32'd0);
    apply_reset();

    // ALU alone, x5 <- DEADBEEF
    drive_cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, ga, gl);
    idle(2);

    // Both valid for four cycles from reset: ALU, LSU, ALU, LSU
    apply_reset();
    for (int i = 0; i < 4; i++)
      drive_cycle(0, 1, 5'd3, 32'hA000_0000 + i, 1, 5'd7, 32'hB000_0000 + i, ga, gl);
    idle(2);
`ifdef WB_ARB_CONFLICT_CNT_EN
    check("conflict_cnt_4", 32'(conflict_cnt), 32'd4);
`endif

    // Load to x0: accepted, no write
    drive_cycle(0, 0, 0, 0, 1, 5'd0, 32'h1234, ga, gl);
    idle(2);

    // Hold with both valid: one contended ALU win first so LSU has priority
    apply_reset();
    drive_cycle(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, ga, gl);
    for (int i = 0; i < 3; i++)
      drive_cycle(1, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66, ga, gl);
    drive_cycle(0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66, ga, gl);
    check("post_hold_lsu_first", 32'(gl), 32'd1);
    idle(2);

    // Reset pulsed the cycle after a contended grant
    drive_cycle(0, 1, 5'd12, 32'hC0FFEE, 1, 5'd13, 32'hBEEF, ga, gl);
    @(posedge clk);
    #1;
    alu_valid = 0; lsu_valid = 0;
    #1;
    rst = 1'b1;
    #1;
    check("rst_pulse_write", 32'(write), 32'd0);
    reset_model();
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h9999;
    #1;
    check("ready_in_reset", 32'(alu_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    alu_valid = 0;
    rst = 1'b0;
    idle(2);
    check("after_rst_write", 32'(write), 32'd0);
    drive_cycle(0, 1, 5'd14, 32'h1414, 1, 5'd15, 32'h1515, ga, gl);
    check("after_rst_pri_alu", 32'(ga), 32'd1);
    idle(2);

`ifdef WB_ARB_CONFLICT_CNT_EN
    // Counter saturation
    apply_reset();
    @(posedge clk);
    #1;
    hold = 0; alu_valid = 1; alu_rd = 0; lsu_valid = 1; lsu_rd = 0;
    repeat (65540) @(posedge clk);
    #1;
    check("conflict_cnt_sat", 32'(conflict_cnt), 32'hFFFF);
    alu_valid = 0; lsu_valid = 0;
    apply_reset();
`endif

    // Random traffic; a losing requester keeps its request stable
    a_keep = 0; l_keep = 0;
    a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_d = 0; l_d = 0;
    for (int i = 0; i < 400; i++) begin
      logic h;
      if (!a_keep) begin
        a_v = ($urandom_range(0, 3) != 0); a_rd = 5'($urandom_range(0, 31)); a_d = $urandom;
      end
      if (!l_keep) begin
        l_v = ($urandom_range(0, 3) != 0); l_rd = 5'($urandom_range(0, 31)); l_d = $urandom;
      end
      h = ($urandom_range(0, 4) == 0);
      drive_cycle(h, a_v, a_rd, a_d, l_v, l_rd, l_d, ga, gl);
      a_keep = a_v && !ga;
      l_keep = l_v && !gl;
    end
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
